// File: rtl/fpu_add_ctrl_if.sv
// Request/response bundle between the FPU issue logic and fpu_add_ctrl.
// Both channels: a transfer occurs on a rising clock edge where valid and ready are both high; the producer holds valid and payload stable until then.
interface fpu_add_ctrl_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        sub_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic [3:0]  rsp_flags_o;

   modport slave (
      input  req_valid_i, op_a_i, op_b_i, sub_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o
   );
   modport master (
      output req_valid_i, op_a_i, op_b_i, sub_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o
   );
endinterface

// File: rtl/fpu_add_ctrl.sv
// Sequencer around the combinational fpu_add datapath: unpack, special-case, normalize, round, pack.
// Optional macro FPU_ADD_CTRL_FAST_NORM_EN: single-cycle leading-zero normalization instead of one bit per cycle.
module fpu_add_ctrl #(
   parameter int NORM_MAX = 26
) (
   input  logic          clk_i,
   input  logic          rst_i,
   fpu_add_ctrl_if.slave bus,
   output logic          busy_o,
   output logic [32:0]   add_a_o,
   output logic [32:0]   add_b_o,
   output logic [2:0]    add_exc_o,
   input  logic [33:0]   add_res_i,
   output logic [2:0]    dbg_state_o
);

   typedef enum logic [2:0] {S_IDLE, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

   state_t      state_q;
   logic [32:0] a_q, b_q;
   logic [2:0]  exc_q;
   logic        snan_q, negz_q;
   logic        sign_q, guard_q;
   logic [9:0]  exp_q;
   logic [24:0] man_q;
   logic [31:0] res_q;
   logic [3:0]  flags_q;
   logic        rsp_valid_q;

   logic [32:0] a_d, b_d;
   logic [2:0]  exc_d;
   logic        snan_d, negz_d, b_sign_d;
   logic        a_nan, b_nan, a_inf, b_inf;
   logic [31:0] canned_res_d;
   logic [3:0]  canned_flags_d;
   logic [24:0] rnd_d;
   logic [23:0] rman_d;
   logic [9:0]  rexp_d;
   logic [31:0] pack_res_d;
   logic [3:0]  pack_flags_d;

   assign bus.req_ready_o  = (state_q == S_IDLE);
   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_result_o = res_q;
   assign bus.rsp_flags_o  = flags_q;
   assign busy_o           = (state_q != S_IDLE);
   assign add_a_o          = a_q;
   assign add_b_o          = b_q;
   assign add_exc_o        = exc_q;
   assign dbg_state_o      = state_q;

   // Operand unpack and special-operand classification at capture time.
   always_comb begin
      b_sign_d = bus.op_b_i[31] ^ bus.sub_i;
      a_d      = {bus.op_a_i[31], bus.op_a_i[30:23], |bus.op_a_i[30:23], bus.op_a_i[22:0]};
      b_d      = {b_sign_d, bus.op_b_i[30:23], |bus.op_b_i[30:23], bus.op_b_i[22:0]};
      a_nan    = (&bus.op_a_i[30:23]) & (|bus.op_a_i[22:0]);
      b_nan    = (&bus.op_b_i[30:23]) & (|bus.op_b_i[22:0]);
      a_inf    = (&bus.op_a_i[30:23]) & ~(|bus.op_a_i[22:0]);
      b_inf    = (&bus.op_b_i[30:23]) & ~(|bus.op_b_i[22:0]);
      snan_d   = (a_nan & ~bus.op_a_i[22]) | (b_nan & ~bus.op_b_i[22]);
      negz_d   = bus.op_a_i[31] & (bus.op_a_i[30:0] == 31'd0) &
                 b_sign_d & (bus.op_b_i[30:0] == 31'd0);
      exc_d    = 3'd0;
      if (a_nan | b_nan)                            exc_d = 3'd1;
      else if (a_inf & b_inf & (bus.op_a_i[31] != b_sign_d)) exc_d = 3'd4;
      else if (a_inf)                               exc_d = bus.op_a_i[31] ? 3'd3 : 3'd2;
      else if (b_inf)                               exc_d = b_sign_d ? 3'd3 : 3'd2;
   end

   always_comb begin
      canned_res_d   = 32'hFF80_0000;
      canned_flags_d = 4'b0000;
      case (exc_q)
         3'd1: begin canned_res_d = 32'h7FC0_0000; canned_flags_d = {snan_q, 3'b000}; end
         3'd4: begin canned_res_d = 32'h7FC0_0000; canned_flags_d = 4'b1000; end
         3'd2: canned_res_d = 32'h7F80_0000;
         default: canned_res_d = 32'hFF80_0000;
      endcase
   end

   // Round-to-nearest-even on the guard bit alone, with carry-out renormalization.
   always_comb begin
      rnd_d = {1'b0, man_q[23:0]} + {24'd0, guard_q & man_q[0]};
      if (rnd_d[24]) begin
         rman_d = rnd_d[24:1];
         rexp_d = exp_q + 10'd1;
      end else begin
         rman_d = rnd_d[23:0];
         rexp_d = exp_q;
      end
      if (rexp_d >= 10'd255) begin
         pack_res_d   = {sign_q, 8'hFF, 23'd0};
         pack_flags_d = 4'b0101;
      end else if ((rexp_d <= 10'd1) && !rman_d[23]) begin
         pack_res_d   = {sign_q, 8'd0, rman_d[22:0]};
         pack_flags_d = {2'b00, guard_q & (rman_d != 24'd0), guard_q};
      end else begin
         pack_res_d   = {sign_q, rexp_d[7:0], rman_d[22:0]};
         pack_flags_d = {3'b000, guard_q};
      end
   end

`ifdef FPU_ADD_CTRL_FAST_NORM_EN
   logic [4:0] lz_d;
   logic [9:0] max_sh_d, sh_d;
   always_comb begin
      lz_d = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (man_q[i]) lz_d = 5'(23 - i);
      end
      max_sh_d = (exp_q > 10'd1) ? (exp_q - 10'd1) : 10'd0;
      sh_d     = ({5'd0, lz_d} < max_sh_d) ? {5'd0, lz_d} : max_sh_d;
   end
`else
   localparam int CW = $clog2(NORM_MAX + 1);
   logic [CW-1:0] cnt_q;
   logic          norm_stop_d;
   // Leave NORM on the shift that normalizes, reaches the denormal floor, or hits the cap.
   assign norm_stop_d = man_q[22] | (exp_q <= 10'd2) | (cnt_q == CW'(NORM_MAX - 1));
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         exc_q       <= '0;
         snan_q      <= 1'b0;
         negz_q      <= 1'b0;
         sign_q      <= 1'b0;
         guard_q     <= 1'b0;
         exp_q       <= '0;
         man_q       <= '0;
         res_q       <= '0;
         flags_q     <= '0;
         rsp_valid_q <= 1'b0;
`ifndef FPU_ADD_CTRL_FAST_NORM_EN
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid_i) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  exc_q   <= exc_d;
                  snan_q  <= snan_d;
                  negz_q  <= negz_d;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               if (exc_q != 3'd0) begin
                  res_q   <= canned_res_d;
                  flags_q <= canned_flags_d;
                  state_q <= S_DONE;
               end else begin
                  sign_q  <= add_res_i[33];
                  exp_q   <= {2'b00, add_res_i[32:25]};
                  man_q   <= add_res_i[24:0];
                  guard_q <= 1'b0;
`ifndef FPU_ADD_CTRL_FAST_NORM_EN
                  cnt_q   <= '0;
`endif
                  state_q <= S_NORM;
               end
            end
            S_NORM: begin
               if (man_q[24]) begin
                  man_q   <= {1'b0, man_q[24:1]};
                  guard_q <= man_q[0];
                  exp_q   <= exp_q + 10'd1;
                  state_q <= S_ROUND;
               end else if (man_q == 25'd0) begin
                  sign_q  <= negz_q;
                  exp_q   <= 10'd0;
                  state_q <= S_ROUND;
`ifdef FPU_ADD_CTRL_FAST_NORM_EN
               end else begin
                  man_q   <= man_q << sh_d;
                  exp_q   <= exp_q - sh_d;
                  state_q <= S_ROUND;
               end
`else
               end else if (!man_q[23] && (exp_q > 10'd1)) begin
                  man_q <= {man_q[23:0], 1'b0};
                  exp_q <= exp_q - 10'd1;
                  cnt_q <= cnt_q + 1'b1;
                  if (norm_stop_d) state_q <= S_ROUND;
               end else begin
                  state_q <= S_ROUND;
               end
`endif
            end
            S_ROUND: begin
               res_q   <= pack_res_d;
               flags_q <= pack_flags_d;
               state_q <= S_DONE;
            end
            S_DONE: begin
               // Result registers settle on DONE entry; valid is raised one cycle later.
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
               end else if (bus.rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fpu_add_ctrl.md
Name: fpu_add_ctrl

Overview:
Multi-cycle sequencer wrapped around the combinational FP add datapath (fpu_add).
- Accepts single-precision add/sub requests over a valid/ready handshake.
- Unpacks operands into the 33-bit {sign, exp[7:0], hidden, frac[22:0]} format and detects special operands, driving the adder's exception code.
- Normalizes the 34-bit {sign, exp, man[24:0]} adder result over one or more cycles, rounds, and packs it.
- Returns an IEEE-754 binary32 result and flags through a response handshake to the FPU issue logic.

Parameters:
- NORM_MAX, 26, left-shift cycle cap in NORM. On reaching it, the block forces pack with the current exponent.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i; high only in IDLE
- op_a_i  in  32  binary32 operand A
- op_b_i  in  32  binary32 operand B
- sub_i  in  1  1 = A-B (B sign inverted at capture)
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer ready
- rsp_result_o  out  32  binary32 result
- rsp_flags_o  out  4  {NV, OF, UF, NX}
- busy_o  out  1  state != IDLE
- add_a_o  out  33  adder operand A {sign, exp, hidden, frac}
- add_b_o  out  33  adder operand B
- add_exc_o  out  3  adder exception code
- add_res_i  in  34  adder result {sign, exp, man[24:0]}

Behaviour:
- Reset (async, rst_i=1): state=IDLE, all datapath registers cleared.
  - During reset: rsp_valid_o=0, rsp_result_o=0, rsp_flags_o=0, busy_o=0, add_*_o=0, req_ready_o=1.
  - Reset mid-operation discards the in-flight op with no response.
- States: IDLE -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on req_valid_i & req_ready_o:
  - Register the operands; B sign ^= sub_i.
  - hidden = (exp != 0).
  - Compute exc:
    - 0 = none
    - 1 = qNaN (any NaN operand)
    - 2 = +Inf
    - 3 = -Inf
    - 4 = invalid (Inf + opposite-signed Inf)
  - Go to ADD.
- ADD, exc != 0: ignore add_res_i. Load canned result and go directly to DONE:
  - exc 1: result 0x7FC00000; NV=1 only if an operand is sNaN.
  - exc 4: result 0x7FC00000, NV=1.
  - exc 2 / 3: result 0x7F800000 / 0xFF800000.
- ADD, exc = 0: register add_res_i; go to NORM.
- NORM, one evaluation per cycle:
  - If man[24]=1: man>>=1, guard=shifted bit, exp+=1, go to ROUND.
  - Else if man==0: result +0. If both operands are -0, result is -0. Go to ROUND.
  - Else if man[23]=0 and exp>1: man<<=1, exp-=1, stay in NORM.
  - Else (normalized, or exp==1 meaning denormal): go to ROUND.
  - The NORM_MAX cap applies in all cases.
  - Latency: NORM occupies max(1, k) cycles for k left shifts.
- ROUND: round-to-nearest-even on the guard bit only (sticky=0; the adder truncates).
  - Increment when guard & man[0]; NX = guard.
  - A mantissa carry-out re-normalizes in the same cycle (exp+1).
  - exp>=255: result ±Inf, OF=1, NX=1.
  - exp==1 & man[23]==0: pack exp field 0; UF=1 if the result is nonzero and NX.
- DONE: rsp_valid_o=1; result and flags held stable until rsp_ready_i. Return to IDLE on the handshake cycle.
  - req_ready_o rises the cycle after the handshake. No back-to-back acceptance in the same cycle.
- Latency, accept edge to first rsp_valid_o cycle:
  - 4 cycles with no left shifts.
  - 3 + k cycles for k >= 1 shifts.
  - 2 cycles for special cases.
- add_a_o, add_b_o, add_exc_o are driven from registers and are stable in every state except IDLE.

Optional Feature:
- Macro FPU_ADD_CTRL_FAST_NORM_EN.
- Defined: NORM uses a leading-zero counter on man[23:0] and completes any left shift in one cycle (shift clamped so exp >= 1). Latency is fixed at 4 cycles (2 for special cases); NORM_MAX is unused.
- Undefined: iterative one-bit-per-cycle NORM as described above.

Test Plan:
- 0x3F800000 + 0x3F800000, sub_i=0 -> rsp_result_o=0x40000000, flags=0, rsp_valid_o 4 cycles after accept.
- 0x3F800001 - 0x3F800000 (sub_i=1) -> 0x34000000, flags=0. Iterative build: 23 NORM cycles, valid at accept+26. FAST_NORM_EN build: accept+4.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000, NV=1, valid at accept+2, adder result ignored.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, OF=1, NX=1.
- 0x3F800000 - 0x3F800000 -> 0x00000000 (+0), flags=0. Hold rsp_ready_i=0 for 5 cycles: result stable, req_ready_o=0, busy_o=1. Handshake, then next cycle req_ready_o=1.
- Assert rst_i mid-NORM during the second test -> same cycle rsp_valid_o=0, busy_o=0. After release, a new 1.0+1.0 request returns 0x40000000 with no stale response.
